bcd_to_bin_seq: RTL and testbench

//  Iterative BCD-to-binary converter. It uses reverse double dabble: shift right, then subtract 3

---
 rtl/bcd_to_bin_seq_if.sv | 34 +++
 rtl/bcd_to_bin_seq.sv | 150 +++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for bcd_to_bin_seq: BCD input channel and binary result channel.
// The converter uses the slave modport; the producer/consumer side uses master.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      out_bin;
    logic                  out_err;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter (reverse double dabble, one shift/correct per clock).
// Optional macro BCD_CHECK_EN: reject inputs with a digit > 9 as out_err=1, out_bin=0, latency 1.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    bcd_to_bin_seq_if.slave     bus,
    output logic                busy
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    // ERR is only reachable when the digit check is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;
    logic [BIN_W-1:0]   out_bin_reg;

    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    genvar gi;

    assign shifted  = {bcd_reg, bin_reg} >> 1;
    assign bin_next = shifted[BIN_W-1:0];

    // A digit that reads >= 8 after the shift received a bit worth 10 from the digit above;
    // subtracting 3 turns that 8 into the 5 it stands for in a halved decimal value.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_correct
            logic [3:0] dig;
            assign dig = shifted[BIN_W + 4*gi +: 4];
            assign bcd_next[4*gi +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
        end
    endgenerate

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0]  digit_bad;
    logic               in_bad;
    logic               out_err_reg;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_check
            assign digit_bad[gi] = (bus.in_bcd[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign in_bad      = |digit_bad;
    assign bus.out_err = out_err_reg;
`else
    assign bus.out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bcd_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            out_bin_reg   <= '0;
`ifdef BCD_CHECK_EN
            out_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        bcd_reg      <= bus.in_bcd;
                        bin_reg      <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
`ifdef BCD_CHECK_EN
                        if (in_bad) begin
                            state_reg <= ERR;
                        end else begin
                            state_reg   <= CONV;
                            busy_reg    <= 1'b1;
                            out_err_reg <= 1'b0;
                        end
`else
                        state_reg <= CONV;
                        busy_reg  <= 1'b1;
`endif
                    end
                end

                CONV: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        out_bin_reg   <= bin_next;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

`ifdef BCD_CHECK_EN
                ERR: begin
                    state_reg     <= DONE;
                    out_valid_reg <= 1'b1;
                    out_bin_reg   <= '0;
                    out_err_reg   <= 1'b1;
                end
`endif

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_bin   = out_bin_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (defaults DIGITS=3, BIN_W=10).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bcd_to_bin_seq;
    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one value in IDLE, then waits (bounded) for out_valid; no checks here.
    task automatic run_conv(input logic [11:0] bcd, output int lat, output int busy_n);
        bus.in_bcd   = bcd;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!bus.out_valid && lat < 40) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        $display("conv in=%h lat=%0d busy_cycles=%0d out_bin=%0d out_err=%0b",
                 bcd, lat, busy_n, bus.out_bin, bus.out_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_bin !== 10'd0) begin failures++; $display("FAIL reset_out_bin got=%0d exp=0", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        $display("reset done");
    endtask

    task automatic test_all_nines();
        int lat, bn;
        bus.out_ready = 1'b1;
        run_conv(12'h999, lat, bn);
        checks++; if (lat !== 10) begin failures++; $display("FAIL t1_latency got=%0d exp=10", lat); end
        checks++; if (bus.out_bin !== 10'd999) begin failures++; $display("FAIL t1_bin got=%0d exp=999", bus.out_bin); end
        checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", bus.out_err); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_drop got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t1_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_values();
        int lat, bn;
        bus.out_ready = 1'b1;
        run_conv(12'h000, lat, bn);
        checks++; if (bus.out_bin !== 10'd0) begin failures++; $display("FAIL t2_zero_bin got=%0d exp=0", bus.out_bin); end
        checks++; if (bn !== 10) begin failures++; $display("FAIL t2_zero_busy got=%0d exp=10", bn); end
        checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL t2_zero_err got=%b exp=0", bus.out_err); end
        tick();
        run_conv(12'h255, lat, bn);
        checks++; if (bus.out_bin !== 10'd255) begin failures++; $display("FAIL t2_255_bin got=%0d exp=255", bus.out_bin); end
        checks++; if (bn !== 10) begin failures++; $display("FAIL t2_255_busy got=%0d exp=10", bn); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL t2_255_latency got=%0d exp=10", lat); end
        tick();
    endtask

    task automatic test_hold();
        int lat, bn;
        bus.out_ready = 1'b0;
        run_conv(12'h407, lat, bn);
        checks++; if (bus.out_bin !== 10'd407) begin failures++; $display("FAIL t3_bin got=%0d exp=407", bus.out_bin); end
        // A pending input must be ignored while the result is held.
        bus.in_bcd   = 12'h321;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bin !== 10'd407 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold cycle=%0d got valid=%b bin=%0d in_ready=%b exp valid=1 bin=407 in_ready=0",
                         i, bus.out_valid, bus.out_bin, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        $display("t3 handshake out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t3_valid_drop got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t3_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_bin !== 10'd407) begin failures++; $display("FAIL t3_bin_kept got=%0d exp=407", bus.out_bin); end
    endtask

    task automatic test_reset_abort();
        int lat, bn;
        bus.out_ready = 1'b1;
        bus.in_bcd    = 12'h123;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("t4 abort in_ready=%b out_valid=%b out_bin=%0d busy=%b",
                 bus.in_ready, bus.out_valid, bus.out_bin, busy);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t4_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t4_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_bin !== 10'd0) begin failures++; $display("FAIL t4_out_bin got=%0d exp=0", bus.out_bin); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_busy got=%b exp=0", busy); end
        run_conv(12'h050, lat, bn);
        checks++; if (bus.out_bin !== 10'd50) begin failures++; $display("FAIL t4_bin got=%0d exp=50", bus.out_bin); end
        tick();
    endtask

    task automatic test_bad_digit();
        int lat, bn;
        bus.out_ready = 1'b1;
        run_conv(12'h1A0, lat, bn);
        checks++; if (bus.out_err !== 1'b0 && bus.out_err !== 1'b1) begin failures++; $display("FAIL t5_err_x got=%b", bus.out_err); end
`ifdef BCD_CHECK_EN
        checks++; if (lat !== 1) begin failures++; $display("FAIL t5_latency got=%0d exp=1", lat); end
        checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL t5_err got=%b exp=1", bus.out_err); end
        checks++; if (bus.out_bin !== 10'd0) begin failures++; $display("FAIL t5_bin got=%0d exp=0", bus.out_bin); end
        checks++; if (bn !== 0) begin failures++; $display("FAIL t5_busy got=%0d exp=0", bn); end
`else
        checks++; if (lat !== 10) begin failures++; $display("FAIL t5_latency got=%0d exp=10", lat); end
        checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL t5_err got=%b exp=0", bus.out_err); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        int n, n2, n3;
        bus.out_ready = 1'b1;
        bus.in_bcd    = 12'h001;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_bcd = 12'h998;
        n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        $display("t6 first result lat=%0d out_bin=%0d", n, bus.out_bin);
        checks++; if (n !== 10) begin failures++; $display("FAIL t6_lat1 got=%0d exp=10", n); end
        checks++; if (bus.out_bin !== 10'd1) begin failures++; $display("FAIL t6_bin1 got=%0d exp=1", bus.out_bin); end
        n2 = 0;
        while (!busy && n2 < 40) begin tick(); n2++; end
        checks++; if (n2 !== 2) begin failures++; $display("FAIL t6_gap got=%0d exp=2", n2); end
        bus.in_valid = 1'b0;
        n3 = 0;
        while (!bus.out_valid && n3 < 40) begin tick(); n3++; end
        $display("t6 second result lat=%0d out_bin=%0d", n3, bus.out_bin);
        checks++; if (n3 !== 10) begin failures++; $display("FAIL t6_lat2 got=%0d exp=10", n3); end
        checks++; if (bus.out_bin !== 10'd998) begin failures++; $display("FAIL t6_bin2 got=%0d exp=998", bus.out_bin); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t6_valid_drop got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_all_nines();
        test_values();
        test_hold();
        test_reset_abort();
        test_bad_digit();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
